// File: rtl/gray_to_rgb_mapper_if.sv
// gray_to_rgb_mapper_if
//   Handshake bundle between the gray/edge stage, the colour mapper and the RGB writer.
//   master : upstream + downstream side (drives gray/mode/thresh/valid_i and ready_i)
//   slave  : the mapper (drives ready_o and the RGB/position-tag outputs)
//   Optional OVERLAY_EN adds overlay_i / overlay_rgb_i ({R,G,B}) toward the mapper.
interface gray_to_rgb_mapper_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 8
);
    logic [IN_W-1:0]    gray_i;
    logic               valid_i;
    logic               ready_o;
    logic [1:0]         mode_i;
    logic [IN_W-1:0]    thresh_i;
    logic [OUT_W-1:0]   red_o;
    logic [OUT_W-1:0]   green_o;
    logic [OUT_W-1:0]   blue_o;
    logic               valid_o;
    logic               ready_i;
    logic               sof_o;
    logic               eol_o;
    logic               done_o;
`ifdef OVERLAY_EN
    logic               overlay_i;
    logic [3*OUT_W-1:0] overlay_rgb_i;
`endif

    modport master (
`ifdef OVERLAY_EN
        output overlay_i, overlay_rgb_i,
`endif
        output gray_i, valid_i, mode_i, thresh_i, ready_i,
        input  ready_o, red_o, green_o, blue_o, valid_o, sof_o, eol_o, done_o
    );

    modport slave (
`ifdef OVERLAY_EN
        input  overlay_i, overlay_rgb_i,
`endif
        input  gray_i, valid_i, mode_i, thresh_i, ready_i,
        output ready_o, red_o, green_o, blue_o, valid_o, sof_o, eol_o, done_o
    );
endinterface

// File: rtl/gray_to_rgb_mapper.sv
// gray_to_rgb_mapper
//   Streaming gray -> RGB colour mapper, 2-stage pipeline, valid/ready on both sides.
//   Modes (latched per frame at the x=0,y=0 pixel): 0 replicate, 1 invert,
//   2 binary threshold, 3 heatmap. Output pixels carry sof/eol/done raster tags.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (flushes pipe, raster position to 0)
//   bus  : gray_to_rgb_mapper_if.slave (gray/mode/thresh/valid_i in, ready_o out,
//          red/green/blue/sof/eol/done/valid_o out, ready_i in)
// Optional feature: define OVERLAY_EN to add per-pixel overlay_i which replaces the
//   mapped colour with overlay_rgb_i (latched at sof) for that pixel.
module gray_to_rgb_mapper #(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 8,
    parameter int FRAME_W = 640,
    parameter int FRAME_H = 480
) (
    input logic                 clk,
    input logic                 rst,
    gray_to_rgb_mapper_if.slave bus
);
    localparam int XW = $clog2(FRAME_W);
    localparam int YW = $clog2(FRAME_H);

    // Top OUT_W bits of {v,v}: bit-replication widening, identity when OUT_W == IN_W.
    function automatic logic [OUT_W-1:0] widen(input logic [IN_W-1:0] v);
        return OUT_W'({v, v} >> (2*IN_W - OUT_W));
    endfunction

    // Raster position of the next pixel to be accepted, and per-frame settings.
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [1:0]      frame_mode;
    logic [IN_W-1:0] frame_thr;

    // Stage 1: gray pixel, its tags, and the frame settings that apply to it.
    logic            s1_valid;
    logic [IN_W-1:0] s1_gray;
    logic [1:0]      s1_mode;
    logic [IN_W-1:0] s1_thr;
    logic            s1_sof, s1_eol, s1_done;

    // Stage 2: final RGB + tags (directly drive the outputs).
    logic             s2_valid;
    logic [OUT_W-1:0] s2_r, s2_g, s2_b;
    logic             s2_sof, s2_eol, s2_done;

`ifdef OVERLAY_EN
    logic [3*OUT_W-1:0] frame_ovl_rgb;
    logic               s1_ovl;
    logic [3*OUT_W-1:0] s1_ovl_rgb;
`endif

    logic s2_load, s1_load, accept;
    logic at_sof, at_eol, at_last;

    assign s2_load = !s2_valid || bus.ready_i;
    assign s1_load = !s1_valid || s2_load;
    assign accept  = bus.valid_i && s1_load;

    assign at_sof  = (x == '0) && (y == '0);
    assign at_eol  = (x == XW'(FRAME_W - 1));
    assign at_last = (y == YW'(FRAME_H - 1));

    // Colour mapping at IN_W on the stage-1 pixel.
    logic [IN_W-1:0] map_r, map_g, map_b, dbl;
    always_comb begin
        // 2g and 2(g-H) are the same value once truncated to IN_W bits,
        // so one doubled term serves both halves of the heatmap.
        dbl   = {s1_gray[IN_W-2:0], 1'b0};
        map_r = s1_gray;
        map_g = s1_gray;
        map_b = s1_gray;
        case (s1_mode)
            2'd0: ;
            2'd1: begin
                map_r = ~s1_gray;
                map_g = ~s1_gray;
                map_b = ~s1_gray;
            end
            2'd2: begin
                map_r = (s1_gray >= s1_thr) ? '1 : '0;
                map_g = map_r;
                map_b = map_r;
            end
            default: begin
                if (!s1_gray[IN_W-1]) begin
                    map_r = '0;
                    map_g = dbl;
                    map_b = ~dbl;
                end else begin
                    map_r = dbl;
                    map_g = ~dbl;
                    map_b = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            frame_mode <= '0;
            frame_thr  <= '0;
            s1_valid   <= 1'b0;
            s1_gray    <= '0;
            s1_mode    <= '0;
            s1_thr     <= '0;
            s1_sof     <= 1'b0;
            s1_eol     <= 1'b0;
            s1_done    <= 1'b0;
            s2_valid   <= 1'b0;
            s2_r       <= '0;
            s2_g       <= '0;
            s2_b       <= '0;
            s2_sof     <= 1'b0;
            s2_eol     <= 1'b0;
            s2_done    <= 1'b0;
`ifdef OVERLAY_EN
            frame_ovl_rgb <= '0;
            s1_ovl        <= 1'b0;
            s1_ovl_rgb    <= '0;
`endif
        end else begin
            if (accept) begin
                if (at_eol) begin
                    x <= '0;
                    y <= at_last ? '0 : y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
                if (at_sof) begin
                    frame_mode <= bus.mode_i;
                    frame_thr  <= bus.thresh_i;
`ifdef OVERLAY_EN
                    frame_ovl_rgb <= bus.overlay_rgb_i;
`endif
                end
            end

            if (s1_load) begin
                s1_valid <= bus.valid_i;
                s1_gray  <= bus.gray_i;
                // The sof pixel uses the live settings; the rest of the frame the latched ones.
                s1_mode  <= at_sof ? bus.mode_i   : frame_mode;
                s1_thr   <= at_sof ? bus.thresh_i : frame_thr;
                s1_sof   <= at_sof;
                s1_eol   <= at_eol;
                s1_done  <= at_eol && at_last;
`ifdef OVERLAY_EN
                s1_ovl     <= bus.overlay_i;
                s1_ovl_rgb <= at_sof ? bus.overlay_rgb_i : frame_ovl_rgb;
`endif
            end

            if (s2_load) begin
                s2_valid <= s1_valid;
                s2_sof   <= s1_valid && s1_sof;
                s2_eol   <= s1_valid && s1_eol;
                s2_done  <= s1_valid && s1_done;
`ifdef OVERLAY_EN
                if (s1_ovl) begin
                    s2_r <= s1_ovl_rgb[3*OUT_W-1 -: OUT_W];
                    s2_g <= s1_ovl_rgb[2*OUT_W-1 -: OUT_W];
                    s2_b <= s1_ovl_rgb[OUT_W-1:0];
                end else begin
                    s2_r <= widen(map_r);
                    s2_g <= widen(map_g);
                    s2_b <= widen(map_b);
                end
`else
                s2_r <= widen(map_r);
                s2_g <= widen(map_g);
                s2_b <= widen(map_b);
`endif
            end
        end
    end

    assign bus.ready_o = s1_load;
    assign bus.valid_o = s2_valid;
    assign bus.red_o   = s2_r;
    assign bus.green_o = s2_g;
    assign bus.blue_o  = s2_b;
    assign bus.sof_o   = s2_sof;
    assign bus.eol_o   = s2_eol;
    assign bus.done_o  = s2_done;
endmodule

// File: tb/tb_gray_to_rgb_mapper.sv
// Bench for gray_to_rgb_mapper: a raster/colour model with a scoreboard queue checks every
// output transfer and stall stability; directed vectors pin literal colours, latency, tags,
// per-frame mode latching and mid-stream reset. A second instance covers OUT_W=10 widening.
module tb_gray_to_rgb_mapper;
    localparam int IN_W = 8, OUT_W = 8, FW = 4, FH = 2;
    localparam int MAXV = (1 << IN_W) - 1, HALF = 1 << (IN_W - 1);

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    gray_to_rgb_mapper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    gray_to_rgb_mapper_if #(.IN_W(IN_W), .OUT_W(10))    bus10 ();

    gray_to_rgb_mapper #(.IN_W(IN_W), .OUT_W(OUT_W), .FRAME_W(FW), .FRAME_H(FH))
        dut (.clk(clk), .rst(rst), .bus(bus));
    gray_to_rgb_mapper #(.IN_W(IN_W), .OUT_W(10), .FRAME_W(FW), .FRAME_H(FH))
        dut10 (.clk(clk), .rst(rst), .bus(bus10));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Spec-level colour rule, plain integer arithmetic at IN_W.
    function automatic void map_pix(input int g, input int mode, input int thr,
                                    output int r, output int gr, output int b);
        case (mode)
            0: begin r = g; gr = g; b = g; end
            1: begin r = MAXV - g; gr = r; b = r; end
            2: begin r = (g >= thr) ? MAXV : 0; gr = r; b = r; end
            default:
                if (g < HALF) begin r = 0; gr = 2*g; b = MAXV - 2*g; end
                else begin r = 2*(g - HALF); gr = MAXV - r; b = 0; end
        endcase
    endfunction

    function automatic int widen(input int v, input int ow);
        return ((v << IN_W) + v) >> (2*IN_W - ow);
    endfunction

    function automatic logic [63:0] pack(input bit s, input bit e, input bit d,
                                         input int r, input int g, input int b);
        logic [63:0] v;
        v = 64'(s);
        v = (v << 1) | 64'(e);
        v = (v << 1) | 64'(d);
        v = (v << OUT_W) | 64'(r);
        v = (v << OUT_W) | 64'(g);
        v = (v << OUT_W) | 64'(b);
        return v;
    endfunction

    typedef struct { int r, g, b; bit sof, eol, done; } exp_t;
    exp_t q[$];
    int   mx = 0, my = 0, fmode = 0, fthr = 0;
    int   out_idx = 0;
    int   rec_red [64];
    bit   rec_sof [64], rec_eol [64], rec_done [64];
    bit   stall_prev = 1'b0;
    logic [63:0] held;

    // Model + scoreboard, evaluated on the falling edge where all DUT signals are settled.
    always @(negedge clk) begin
        logic [63:0] act;
        exp_t e;
        int r, g, b;
        if (rst) begin
            q.delete();
            mx = 0; my = 0; out_idx = 0; stall_prev = 1'b0;
        end else begin
            act = pack(bus.sof_o, bus.eol_o, bus.done_o, bus.red_o, bus.green_o, bus.blue_o);
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.valid_o), 64'd1);
                chk("stall_stable", act, held);
            end
            stall_prev = bus.valid_o && !bus.ready_i;
            held = act;
            if (bus.valid_o && bus.ready_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 64'(out_idx), 64'hFFFF);
                end else begin
                    e = q.pop_front();
                    chk("scoreboard", act, pack(e.sof, e.eol, e.done,
                                                widen(e.r, OUT_W), widen(e.g, OUT_W), widen(e.b, OUT_W)));
                end
                if (out_idx < 64) begin
                    rec_red[out_idx] = bus.red_o; rec_sof[out_idx] = bus.sof_o;
                    rec_eol[out_idx] = bus.eol_o; rec_done[out_idx] = bus.done_o;
                end
                out_idx++;
            end
            if (bus.valid_i && bus.ready_o) begin
                e.sof  = (mx == 0 && my == 0);
                e.eol  = (mx == FW - 1);
                e.done = e.eol && (my == FH - 1);
                if (e.sof) begin fmode = bus.mode_i; fthr = bus.thresh_i; end
                map_pix(bus.gray_i, fmode, fthr, r, g, b);
                e.r = r; e.g = g; e.b = b;
                q.push_back(e);
                mx++;
                if (mx == FW) begin mx = 0; my = (my + 1) % FH; end
            end
        end
    end

    // All tasks start and end just after a rising edge (#1), so drives never race the clock.
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.valid_i = 1'b0; bus10.valid_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic lit(input string nm, input int gray, input int mode, input int thr,
                       input int er, input int eg, input int eb);
        do_reset();
        bus.ready_i = 1'b1; bus.valid_i = 1'b1;
        bus.gray_i = IN_W'(gray); bus.mode_i = 2'(mode); bus.thresh_i = IN_W'(thr);
        step();
        bus.valid_i = 1'b0;
        chk({nm, "_lat1"}, 64'(bus.valid_o), 64'd0);
        step();
        chk({nm, "_valid"}, 64'(bus.valid_o), 64'd1);
        chk({nm, "_rgb"}, {40'd0, bus.red_o, bus.green_o, bus.blue_o},
            {40'd0, 8'(er), 8'(eg), 8'(eb)});
    endtask

    initial begin
        int r, g, b, n;
        bus.valid_i = 0; bus.ready_i = 1; bus.gray_i = 0; bus.mode_i = 0; bus.thresh_i = 0;
        bus10.valid_i = 0; bus10.ready_i = 1; bus10.gray_i = 0; bus10.mode_i = 0; bus10.thresh_i = 0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_ready_o", 64'(bus.ready_o), 64'd1);
        chk("rst_rgb", {40'd0, bus.red_o, bus.green_o, bus.blue_o}, 64'd0);
        chk("rst_tags", {61'd0, bus.sof_o, bus.eol_o, bus.done_o}, 64'd0);

        // Pin the model itself against hand-computed values.
        map_pix(8'h40, 3, 0, r, g, b);
        chk("model_heat_lo", 64'((r << 16) | (g << 8) | b), 64'h00807F);
        map_pix(8'hC0, 3, 0, r, g, b);
        chk("model_heat_hi", 64'((r << 16) | (g << 8) | b), 64'h807F00);
        chk("model_widen10", 64'(widen(8'hFF, 10)), 64'h3FF);

        // Directed colour vectors.
        lit("mode0_5A",  8'h5A, 0, 0,     8'h5A, 8'h5A, 8'h5A);
        lit("mode1_10",  8'h10, 1, 0,     8'hEF, 8'hEF, 8'hEF);
        lit("mode2_7F",  8'h7F, 2, 8'h80, 8'h00, 8'h00, 8'h00);
        lit("mode2_80",  8'h80, 2, 8'h80, 8'hFF, 8'hFF, 8'hFF);
        lit("mode3_40",  8'h40, 3, 0,     8'h00, 8'h80, 8'h7F);
        lit("mode3_C0",  8'hC0, 3, 0,     8'h80, 8'h7F, 8'h00);

        // OUT_W=10 widening on the second instance.
        do_reset();
        bus10.valid_i = 1; bus10.gray_i = 8'hFF; bus10.mode_i = 0;
        step();
        bus10.valid_i = 0;
        step();
        chk("w10_rgb", {34'd0, bus10.red_o, bus10.green_o, bus10.blue_o},
            {34'd0, 10'h3FF, 10'h3FF, 10'h3FF});

        // Raster tags and per-frame mode latching: mode switches at pix2, applies at pix8.
        do_reset();
        bus.ready_i = 1;
        for (int i = 0; i < 9; i++) begin
            bus.valid_i = 1; bus.gray_i = 8'h10; bus.mode_i = (i >= 2) ? 2'd1 : 2'd0;
            step();
        end
        bus.valid_i = 0;
        repeat (3) step();
        chk("frame_count", 64'(out_idx), 64'd9);
        chk("sof_pix0", 64'(rec_sof[0]), 64'd1);
        chk("sof_pix4", 64'(rec_sof[4]), 64'd0);
        chk("eol_pix3", 64'(rec_eol[3]), 64'd1);
        chk("eol_pix2", 64'(rec_eol[2]), 64'd0);
        chk("done_pix3", 64'(rec_done[3]), 64'd0);
        chk("done_pix7", 64'(rec_done[7]), 64'd1);
        chk("eol_pix7", 64'(rec_eol[7]), 64'd1);
        chk("sof_pix8", 64'(rec_sof[8]), 64'd1);
        chk("mode_hold_pix7", 64'(rec_red[7]), 64'h10);
        chk("mode_new_pix8", 64'(rec_red[8]), 64'hEF);

        // Random valid/ready stalls, random mode/threshold; scoreboard checks every transfer.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.valid_i  = ($urandom_range(3) != 0);
            bus.ready_i  = ($urandom_range(2) != 0);
            bus.gray_i   = IN_W'($urandom);
            bus.mode_i   = 2'($urandom);
            bus.thresh_i = IN_W'($urandom);
            step();
        end
        bus.valid_i = 0; bus.ready_i = 1;
        n = 0;
        while (q.size() != 0 && n < 20) begin step(); n++; end
        chk("drain_empty", 64'(q.size()), 64'd0);

        // Reset with both stages full.
        do_reset();
        bus.mode_i = 0;
        for (int i = 0; i < 5; i++) begin
            bus.valid_i = 1; bus.ready_i = 1; bus.gray_i = IN_W'(i); step();
        end
        bus.ready_i = 0;
        repeat (3) step();
        chk("full_ready_o", 64'(bus.ready_o), 64'd0);
        chk("full_valid_o", 64'(bus.valid_o), 64'd1);
        rst = 1; bus.valid_i = 0;
        step();
        rst = 0;
        chk("flush_valid_o", 64'(bus.valid_o), 64'd0);
        chk("flush_ready_o", 64'(bus.ready_o), 64'd1);
        bus.valid_i = 1; bus.ready_i = 1; bus.gray_i = 8'h33;
        step();
        bus.valid_i = 0;
        step();
        chk("post_rst_valid", 64'(bus.valid_o), 64'd1);
        chk("post_rst_sof", 64'(bus.sof_o), 64'd1);
        repeat (2) step();
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
